// File: rtl/edge_result_writer_pkg.sv
// edge_result_writer_pkg: shared image sizes, FSM state encoding and binarized pixel levels
package edge_result_writer_pkg;
  localparam int IMG_W = 32;
  localparam int IMG_H = 32;
  localparam int ADDR_W = 10;
  localparam logic [7:0] BIN_HI = 8'hFF;
  localparam logic [7:0] BIN_LO = 8'h00;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/edge_result_writer_if.sv
// edge_result_writer_if: edge sample stream in, result RAM write port and frame status out
interface edge_result_writer_if #(parameter int AW = edge_result_writer_pkg::ADDR_W);
  logic valid, res_ready, res_wr, overflow, done;
  logic [7:0] edge_in, threshold, res_data, max_mag;
  logic [AW-1:0] res_addr;
  logic [AW:0] edge_cnt;
  modport master(output valid, edge_in, threshold, res_ready,
                 input res_wr, res_addr, res_data, edge_cnt, max_mag, overflow, done);
  modport slave(input valid, edge_in, threshold, res_ready,
                output res_wr, res_addr, res_data, edge_cnt, max_mag, overflow, done);
endinterface

// File: rtl/edge_wr_fifo.sv
// edge_wr_fifo: synchronous FIFO; a push into a full FIFO is only accepted alongside a pop
module edge_wr_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [WIDTH-1:0]         head
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  always_comb begin
    empty = cnt_q == '0;
    full = cnt_q == (PW+1)'(DEPTH);
    level = cnt_q;
    head = mem_q[rd_q];
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d = wr_q + PW'(do_push);
    rd_d = rd_q + PW'(do_pop);
    cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/edge_result_writer.sv
// edge_result_writer: thresholds the edge stream, buffers {pixel index, data} for the result RAM,
// and keeps frame statistics plus a done flag
module edge_result_writer #(
  parameter int IMG_W      = edge_result_writer_pkg::IMG_W,
  parameter int IMG_H      = edge_result_writer_pkg::IMG_H,
  parameter int ADDR_W     = edge_result_writer_pkg::ADDR_W,
  parameter int FIFO_DEPTH = 4,
  parameter int BINARIZE   = 1
) (
  input logic clk,
  input logic rst,
  edge_result_writer_if.slave b
);
  import edge_result_writer_pkg::*;
  localparam int NPIX = IMG_W * IMG_H;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pix_q, pix_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic [7:0] max_q, max_d, data;
  logic ovf_q, ovf_d, take, hit, last, pop, empties, full, empty;
  logic [$clog2(FIFO_DEPTH):0] level;
  logic [ADDR_W+7:0] head;
  edge_wr_fifo #(.WIDTH(ADDR_W + 8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(take), .pop(pop), .din({pix_q, data}),
    .full(full), .empty(empty), .level(level), .head(head)
  );
  always_comb begin
    take = b.valid && (state_q == IDLE || state_q == RUN);
    hit = b.edge_in >= b.threshold;
    data = BINARIZE != 0 ? (hit ? BIN_HI : BIN_LO) : b.edge_in;
    last = take && pix_q == ADDR_W'(NPIX - 1);
    pop = !empty && b.res_ready;
    empties = pop && level == 1 && !take;
    pix_d = pix_q + ADDR_W'(take);
    cnt_d = cnt_q + (ADDR_W+1)'(take && hit);
    max_d = take && b.edge_in > max_q ? b.edge_in : max_q;
    ovf_d = ovf_q || (take && full && !pop);
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = take ? RUN : IDLE;
      RUN:     state_d = last ? (empties ? DONE : DRAIN) : RUN;
      DRAIN:   state_d = empties ? DONE : DRAIN;
      default: state_d = DONE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      pix_q <= '0;
      cnt_q <= '0;
      max_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_q <= pix_d;
      cnt_q <= cnt_d;
      max_q <= max_d;
      ovf_q <= ovf_d;
    end
  // head is gated so the unreset buffer never shows on the RAM port while empty
  always_comb begin
    b.res_wr = !empty;
    b.res_addr = empty ? '0 : head[ADDR_W+7:8];
    b.res_data = empty ? '0 : head[7:0];
    b.edge_cnt = cnt_q;
    b.max_mag = max_q;
    b.overflow = ovf_q;
    b.done = state_q == DONE;
  end
endmodule

// File: tb/tb_edge_result_writer.sv
// tb_edge_result_writer: queue-based frame model checked every cycle against a binarizing
// and a raw-magnitude instance driven by the same stream
module tb_edge_result_writer;
  logic clk = 1'b0, rst = 1'b1, valid = 1'b0, res_ready = 1'b1;
  logic [7:0] edge_in = '0, threshold = '0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  edge_result_writer_if ifb();
  edge_result_writer_if ifr();
  assign ifb.valid = valid;
  assign ifb.edge_in = edge_in;
  assign ifb.threshold = threshold;
  assign ifb.res_ready = res_ready;
  assign ifr.valid = valid;
  assign ifr.edge_in = edge_in;
  assign ifr.threshold = threshold;
  assign ifr.res_ready = res_ready;
  edge_result_writer #(.BINARIZE(1)) u_bin (.clk(clk), .rst(rst), .b(ifb));
  edge_result_writer #(.BINARIZE(0)) u_raw (.clk(clk), .rst(rst), .b(ifr));

  typedef struct packed {logic [9:0] a; logic [7:0] e; logic h;} ent_t;
  ent_t q[$];
  int m_taken, m_cnt, m_max;
  bit m_ovf;
  int dut_wr, first_addr;
  bit dut_written [1024];

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", n, act, exp, $time);
    end
  endtask

  // frame model: one 1024-sample frame, 4-entry buffer, pop before push on each edge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_taken = 0; m_cnt = 0; m_max = 0; m_ovf = 0;
    end else begin
      if (q.size() != 0 && res_ready) void'(q.pop_front());
      if (valid && m_taken < 1024) begin
        if (q.size() < 4) q.push_back({m_taken[9:0], edge_in, edge_in >= threshold});
        else m_ovf = 1;
        if (edge_in >= threshold) m_cnt++;
        if (int'(edge_in) > m_max) m_max = int'(edge_in);
        m_taken++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      dut_wr = 0; first_addr = -1;
      for (int i = 0; i < 1024; i++) dut_written[i] = 0;
    end else begin
      chk("res_wr", int'(ifb.res_wr), int'(q.size() != 0));
      chk("raw_res_wr", int'(ifr.res_wr), int'(q.size() != 0));
      if (q.size() != 0) begin
        chk("res_addr", int'(ifb.res_addr), int'(q[0].a));
        chk("res_data", int'(ifb.res_data), q[0].h ? 255 : 0);
        chk("raw_res_addr", int'(ifr.res_addr), int'(q[0].a));
        chk("raw_res_data", int'(ifr.res_data), int'(q[0].e));
      end
      chk("edge_cnt", int'(ifb.edge_cnt), m_cnt);
      chk("raw_edge_cnt", int'(ifr.edge_cnt), m_cnt);
      chk("max_mag", int'(ifb.max_mag), m_max);
      chk("overflow", int'(ifb.overflow), int'(m_ovf));
      chk("done", int'(ifb.done), int'(m_taken == 1024 && q.size() == 0));
      if (ifb.res_wr && res_ready) begin
        dut_wr++;
        dut_written[ifb.res_addr] = 1;
        if (first_addr < 0) first_addr = int'(ifb.res_addr);
      end
    end
  end

  task automatic do_reset();
    rst = 1; valid = 0; res_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  // mode 1 ramp, 2 short stall, 3 bubble then long stall, 4 random
  task automatic frame(input int mode, input int stop_at);
    int idx = 0;
    bit bub = 0;
    while (idx < stop_at) begin
      valid = 1; res_ready = 1;
      if (mode == 4) begin
        valid = $urandom_range(0, 3) != 0;
        res_ready = $urandom_range(0, 3) != 0;
        edge_in = 8'($urandom);
      end else begin
        edge_in = idx[7:0];
        threshold = 8'd128;
      end
      if (mode == 2 && idx >= 300 && idx < 303) res_ready = 0;
      if (mode == 3 && idx == 100 && !bub) begin
        valid = 0; bub = 1;
      end else if (mode == 3 && idx >= 100 && idx < 110) res_ready = 0;
      @(posedge clk); #1;
      if (valid) idx++;
      if (mode == 3 && valid && idx == 111) chk("full_push_pop_head", int'(ifb.res_addr), 101);
    end
    valid = 0; res_ready = 1;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!ifb.done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_timeout", int'(ifb.done), 1);
  endtask

  initial begin
    do_reset();
    chk("reset_res_wr", int'(ifb.res_wr), 0);
    chk("reset_done", int'(ifb.done), 0);
    frame(1, 1024);
    wait_done();
    chk("t1_writes", dut_wr, 1024);
    chk("t1_edge_cnt", int'(ifb.edge_cnt), 512);
    chk("t1_max_mag", int'(ifb.max_mag), 255);
    chk("t1_overflow", int'(ifb.overflow), 0);
    do_reset();
    frame(2, 1024);
    wait_done();
    chk("t2_writes", dut_wr, 1024);
    chk("t2_overflow", int'(ifb.overflow), 0);
    do_reset();
    frame(3, 1024);
    wait_done();
    chk("t3_writes", dut_wr, 1018);
    chk("t3_overflow", int'(ifb.overflow), 1);
    chk("t3_addr103", int'(dut_written[103]), 1);
    chk("t3_addr104", int'(dut_written[104]), 0);
    chk("t3_addr109", int'(dut_written[109]), 0);
    chk("t3_addr110", int'(dut_written[110]), 1);
    do_reset();
    frame(1, 500);
    do_reset();
    chk("t5_res_wr", int'(ifb.res_wr), 0);
    chk("t5_res_addr", int'(ifb.res_addr), 0);
    chk("t5_edge_cnt", int'(ifb.edge_cnt), 0);
    chk("t5_max_mag", int'(ifb.max_mag), 0);
    frame(1, 1024);
    wait_done();
    chk("t5_first_addr", first_addr, 0);
    chk("t5_writes", dut_wr, 1024);
    do_reset();
    threshold = 8'h37; edge_in = 8'h37; valid = 1;
    @(posedge clk); #1;
    valid = 0;
    chk("t6_raw_data", int'(ifr.res_data), 'h37);
    chk("t6_bin_data", int'(ifb.res_data), 'hFF);
    chk("t6_edge_cnt", int'(ifr.edge_cnt), 1);
    edge_in = 8'h36; valid = 1;
    @(posedge clk); #1;
    valid = 0;
    chk("t6_below_cnt", int'(ifr.edge_cnt), 1);
    for (int r = 0; r < 2; r++) begin
      do_reset();
      threshold = 8'($urandom);
      frame(4, 1024);
      wait_done();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
